// File: rtl/ro_slot_scheduler.sv
// Binary-weighted time-slot scheduler for the shared readout bus.
// Holds per-channel event/polarity until the channel's slot arrives and flags lost events.
module ro_slot_scheduler #(
  parameter int NCH = 8,
  parameter int CW  = 3
) (
  input  logic           clk_master,
  input  logic           rstb,
  input  logic           en,
  input  logic [NCH-1:0] ch_mask,
  input  logic [NCH-1:0] ev_in,
  input  logic [NCH-1:0] pol_in,
  input  logic           ovf_clr,
  output logic [NCH-1:0] sel,
  output logic [CW-1:0]  out_ch,
  output logic           out_valid,
  output logic           out_eve,
  output logic           out_pol_eve,
  output logic           frame_sync,
  output logic [NCH-1:0] ovf
);

  logic [NCH-1:0] r_cnt;
  logic [NCH-1:0] r_pend;
  logic [NCH-1:0] r_pol;
  logic [NCH-1:0] r_ovf;
  logic [NCH-1:0] r_sel;
  logic [CW-1:0]  r_out_ch;
  logic           r_out_valid;
  logic           r_out_eve;
  logic           r_out_pol_eve;
  logic           r_frame_sync;

  logic [CW-1:0]  w_owner;
  logic           w_frame;
  logic [NCH-1:0] w_grant;
  logic [NCH-1:0] w_pend_nxt;
  logic [NCH-1:0] w_pol_nxt;
  logic [NCH-1:0] w_ovf_set;

  // Slot owner is the index of the lowest zero bit of the counter; all ones is the frame slot.
  always_comb begin
    w_owner = '0;
    w_frame = 1'b1;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (w_frame && !r_cnt[i]) begin
        w_owner = CW'(i);
        w_frame = 1'b0;
      end
    end
  end

  assign w_grant = (en && !w_frame) ? (NCH'(1) << w_owner) : '0;

  always_comb begin
    w_pend_nxt = r_pend;
    w_pol_nxt  = r_pol;
    w_ovf_set  = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      if (!ch_mask[k]) begin
        w_pend_nxt[k] = 1'b0;
      end else if (ev_in[k]) begin
        // A same-cycle grant consumes the old event, so the reload is not a loss.
        w_pend_nxt[k] = 1'b1;
        w_pol_nxt[k]  = pol_in[k];
        w_ovf_set[k]  = r_pend[k] & ~w_grant[k];
      end else if (w_grant[k]) begin
        w_pend_nxt[k] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_master or negedge rstb) begin
    if (!rstb) begin
      r_cnt  <= '0;
      r_pend <= '0;
      r_pol  <= '0;
      r_ovf  <= '0;
    end else begin
      if (en) begin
        r_cnt <= r_cnt + NCH'(1);
      end
      r_pend <= w_pend_nxt;
      r_pol  <= w_pol_nxt;
      r_ovf  <= (ovf_clr ? '0 : r_ovf) | w_ovf_set;
    end
  end

  always_ff @(posedge clk_master or negedge rstb) begin
    if (!rstb) begin
      r_sel         <= '0;
      r_out_ch      <= '0;
      r_out_valid   <= 1'b0;
      r_out_eve     <= 1'b0;
      r_out_pol_eve <= 1'b0;
      r_frame_sync  <= 1'b0;
    end else if (!en) begin
      r_sel         <= '0;
      r_out_valid   <= 1'b0;
      r_out_eve     <= 1'b0;
      r_out_pol_eve <= 1'b0;
      r_frame_sync  <= 1'b0;
    end else if (w_frame) begin
      r_sel         <= '0;
      r_out_ch      <= '0;
      r_out_valid   <= 1'b0;
      r_out_eve     <= 1'b0;
      r_out_pol_eve <= 1'b0;
      r_frame_sync  <= 1'b1;
    end else begin
      r_sel         <= w_grant;
      r_out_ch      <= w_owner;
      r_out_valid   <= r_pend[w_owner];
      r_out_eve     <= r_pend[w_owner];
      r_out_pol_eve <= r_pend[w_owner] & r_pol[w_owner];
      r_frame_sync  <= 1'b0;
    end
  end

  assign sel         = r_sel;
  assign out_ch      = r_out_ch;
  assign out_valid   = r_out_valid;
  assign out_eve     = r_out_eve;
  assign out_pol_eve = r_out_pol_eve;
  assign frame_sync  = r_frame_sync;
  assign ovf         = r_ovf;

endmodule

// File: tb/tb_ro_slot_scheduler.sv
// Self-checking bench for ro_slot_scheduler (NCH=3): directed scenarios plus random
// traffic compared against an arithmetic reference model of the slot schedule.
module tb_ro_slot_scheduler;

  logic       clk_master = 1'b0;
  logic       rstb;
  logic       en;
  logic [2:0] ch_mask;
  logic [2:0] ev_in;
  logic [2:0] pol_in;
  logic       ovf_clr;
  logic [2:0] sel;
  logic [1:0] out_ch;
  logic       out_valid;
  logic       out_eve;
  logic       out_pol_eve;
  logic       frame_sync;
  logic [2:0] ovf;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  int m_cnt;
  bit m_pend [3];
  bit m_pol  [3];
  bit m_ovf  [3];
  logic [2:0] e_sel;
  logic [1:0] e_ch;
  logic       e_valid;
  logic       e_pol_eve;
  logic       e_fs;
  logic [2:0] e_ovf;

  ro_slot_scheduler #(.NCH(3), .CW(2)) dut (
    .clk_master (clk_master),
    .rstb       (rstb),
    .en         (en),
    .ch_mask    (ch_mask),
    .ev_in      (ev_in),
    .pol_in     (pol_in),
    .ovf_clr    (ovf_clr),
    .sel        (sel),
    .out_ch     (out_ch),
    .out_valid  (out_valid),
    .out_eve    (out_eve),
    .out_pol_eve(out_pol_eve),
    .frame_sync (frame_sync),
    .ovf        (ovf)
  );

  always #5 clk_master = ~clk_master;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0;
    for (int k = 0; k < 3; k++) begin
      m_pend[k] = 0; m_pol[k] = 0; m_ovf[k] = 0;
    end
    e_sel = '0; e_ch = '0; e_valid = 0; e_pol_eve = 0; e_fs = 0; e_ovf = '0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".sel"},      {5'd0, sel},         {5'd0, e_sel});
    chk({tag, ".out_ch"},   {6'd0, out_ch},      {6'd0, e_ch});
    chk({tag, ".valid"},    {7'd0, out_valid},   {7'd0, e_valid});
    chk({tag, ".eve"},      {7'd0, out_eve},     {7'd0, e_valid});
    chk({tag, ".pol_eve"},  {7'd0, out_pol_eve}, {7'd0, e_pol_eve});
    chk({tag, ".frame"},    {7'd0, frame_sync},  {7'd0, e_fs});
    chk({tag, ".ovf"},      {5'd0, ovf},         {5'd0, e_ovf});
  endtask

  // One clock: drive inputs, predict from the schedule rules, then compare after the edge.
  task automatic step(input bit t_en, input logic [2:0] t_mask, input logic [2:0] t_ev,
                      input logic [2:0] t_pol, input bit t_clr, input string tag);
    int owner;
    int v;
    bit frame;
    bit grant;
    en = t_en; ch_mask = t_mask; ev_in = t_ev; pol_in = t_pol; ovf_clr = t_clr;
    // Channel k owns the slots where cnt+1 is divisible by exactly 2^k.
    v = m_cnt + 1;
    frame = (v == 8);
    owner = 0;
    if (!frame) begin
      while (v % 2 == 0) begin
        v = v / 2;
        owner++;
      end
    end
    if (t_en) begin
      if (frame) begin
        e_sel = '0; e_ch = '0; e_valid = 0; e_pol_eve = 0; e_fs = 1;
      end else begin
        e_sel = 3'(1 << owner);
        e_ch = 2'(owner);
        e_valid = m_pend[owner];
        e_pol_eve = m_pend[owner] && m_pol[owner];
        e_fs = 0;
      end
    end else begin
      e_sel = '0; e_valid = 0; e_pol_eve = 0; e_fs = 0;
    end
    for (int k = 0; k < 3; k++) begin
      if (t_clr) m_ovf[k] = 0;
    end
    for (int k = 0; k < 3; k++) begin
      grant = t_en && !frame && (owner == k);
      if (!t_mask[k]) m_pend[k] = 0;
      else if (t_ev[k]) begin
        if (m_pend[k] && !grant) m_ovf[k] = 1;
        m_pend[k] = 1;
        m_pol[k] = t_pol[k];
      end else if (grant) m_pend[k] = 0;
      e_ovf[k] = m_ovf[k];
    end
    if (t_en) m_cnt = (m_cnt + 1) % 8;
    @(posedge clk_master);
    #1;
    check_all(tag);
  endtask

  task automatic idle_to(input int c);
    int n;
    n = 0;
    while (m_cnt != c && n < 20) begin
      step(1, 3'b111, 3'b000, 3'b000, 0, "align");
      n++;
    end
  endtask

  logic [2:0] sel_tab [8];
  logic [1:0] ch_tab  [8];

  initial begin
    sel_tab = '{3'b001, 3'b010, 3'b001, 3'b100, 3'b001, 3'b010, 3'b001, 3'b000};
    ch_tab  = '{2'd0, 2'd1, 2'd0, 2'd2, 2'd0, 2'd1, 2'd0, 2'd0};
    rstb = 1'b0; en = 0; ch_mask = 3'b111; ev_in = '0; pol_in = '0; ovf_clr = 0;
    model_reset();
    #12;
    check_all("reset");
    rstb = 1'b1;

    // Plain schedule over two frames
    for (int i = 0; i < 16; i++) begin
      step(1, 3'b111, 3'b000, 3'b000, 0, "sched");
      chk("sched_tab.sel", {5'd0, sel}, {5'd0, sel_tab[i % 8]});
      chk("sched_tab.ch", {6'd0, out_ch}, {6'd0, ch_tab[i % 8]});
      chk("sched_tab.fs", {7'd0, frame_sync}, {7'd0, (i % 8 == 7)});
    end

    // Single event on ch2 latched at cnt=0, granted after cnt=3
    idle_to(0);
    step(1, 3'b111, 3'b100, 3'b100, 0, "ev2");
    idle_to(3);
    step(1, 3'b111, 3'b000, 3'b000, 0, "ev2_grant");
    chk("ev2.sel", {5'd0, sel}, 8'h04);
    chk("ev2.valid", {7'd0, out_valid}, 8'h01);
    chk("ev2.pol", {7'd0, out_pol_eve}, 8'h01);
    idle_to(3);
    step(1, 3'b111, 3'b000, 3'b000, 0, "ev2_next");
    chk("ev2_next.valid", {7'd0, out_valid}, 8'h00);

    // Overflow on ch1, newest polarity wins, clear vs set priority
    idle_to(2);
    step(1, 3'b111, 3'b010, 3'b000, 0, "ovf_a");
    step(1, 3'b111, 3'b010, 3'b010, 0, "ovf_b");
    chk("ovf.set", {5'd0, ovf}, 8'h02);
    idle_to(5);
    step(1, 3'b111, 3'b000, 3'b000, 0, "ovf_grant");
    chk("ovf_grant.valid", {7'd0, out_valid}, 8'h01);
    chk("ovf_grant.pol", {7'd0, out_pol_eve}, 8'h01);
    step(1, 3'b111, 3'b010, 3'b000, 0, "ovf_c");
    step(1, 3'b111, 3'b010, 3'b000, 1, "ovf_clrset");
    chk("ovf.clrset", {5'd0, ovf}, 8'h02);
    step(1, 3'b111, 3'b000, 3'b000, 1, "ovf_clr");
    chk("ovf.clr", {5'd0, ovf}, 8'h00);

    // Same-cycle grant and event on ch0
    idle_to(0);
    idle_to(2);
    step(1, 3'b111, 3'b001, 3'b001, 0, "same");
    chk("same.valid", {7'd0, out_valid}, 8'h00);
    chk("same.ovf0", {7'd0, ovf[0]}, 8'h00);
    step(1, 3'b111, 3'b000, 3'b000, 0, "same_b");
    step(1, 3'b111, 3'b000, 3'b000, 0, "same_grant");
    chk("same_grant.valid", {7'd0, out_valid}, 8'h01);

    // en low for 5 cycles at cnt=3, then resume
    idle_to(3);
    for (int i = 0; i < 5; i++) begin
      step(0, 3'b111, 3'b000, 3'b000, 0, "hold");
      chk("hold.sel", {5'd0, sel}, 8'h00);
    end
    step(1, 3'b111, 3'b000, 3'b000, 0, "resume");
    chk("resume.sel", {5'd0, sel}, 8'h04);

    // Masked ch0 keeps its slots
    for (int i = 0; i < 8; i++) begin
      step(1, 3'b110, 3'b001, 3'b001, 0, "mask");
      if (sel == 3'b001) chk("mask.valid", {7'd0, out_valid}, 8'h00);
    end

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 9) != 0,
           ($urandom_range(0, 7) == 0) ? 3'($urandom) : 3'b111,
           3'($urandom & $urandom), 3'($urandom), $urandom_range(0, 15) == 0, "rnd");
    end

    // Build pend=111 / ovf=010, then asynchronous reset between edges
    for (int i = 0; i < 8; i++) step(1, 3'b111, 3'b000, 3'b000, 0, "drain");
    step(1, 3'b111, 3'b000, 3'b000, 1, "pre_clr");
    idle_to(2);
    step(1, 3'b111, 3'b010, 3'b000, 0, "pre_a");
    step(1, 3'b111, 3'b111, 3'b111, 0, "pre_b");
    chk("pre.ovf", {5'd0, ovf}, 8'h02);
    en = 1; ev_in = '0; ovf_clr = 0;
    #3;
    rstb = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    #2;
    rstb = 1'b1;
    step(1, 3'b111, 3'b000, 3'b000, 0, "post_first");
    chk("post_first.sel", {5'd0, sel}, 8'h01);
    for (int i = 0; i < 8; i++) begin
      step(1, 3'b111, 3'b000, 3'b000, 0, "post");
      chk("post.valid", {7'd0, out_valid}, 8'h00);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
